source_msg_packer: RTL

Per-source upstream stage of the USB slave-FIFO writer. It takes a byte stream from one source receiver and packs it into 16-bit words in an internal show-ahead FIFO. It delimits messages by an inter-byte gap or by the 255-word limit. Towards the writer it presents GOT_FULL_MSG, MSG_LEN, PARITY and Q, and it consumes RD_REQ and MSG_START. One instance exists per source, `NUM_SOURCES in total, and their outputs are concatenated into the writer's bus ports.

---
 rtl/source_msg_packer_pkg.sv | 19 +
 rtl/word_fifo_sc.sv | 55 +++++
 rtl/source_msg_packer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/source_msg_packer_pkg.sv
// Shared types and constants for the per-source message packer and its writer.
package source_msg_packer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVEN = 2'd1,
        S_ODD  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam int         GAP_CYCLES_DEF = 1000;
    localparam logic [7:0] MSG_LEN_MAX    = 8'd255;

    typedef struct packed {
        logic       parity;
        logic [7:0] len;
    } len_entry_t;

endpackage

// File: rtl/word_fifo_sc.sv
// Single-clock show-ahead 16-bit FIFO, depth 2^AW, with a tail rewind that
// discards the newest flush_len words when flush_n is low.
module word_fifo_sc #(
    parameter int AW = 9
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wrreq,
    input  logic [15:0]   data,
    input  logic          rdreq,
    input  logic          flush_n,
    input  logic [AW:0]   flush_len,
    output logic [15:0]   q,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   usedw
);

    localparam int DEPTH = 1 << AW;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_wr;
    logic          do_rd;
    logic [AW:0]   drop;

    assign full  = (usedw == (AW+1)'(DEPTH));
    assign empty = (usedw == '0);
    assign do_wr = wrreq && !full;
    assign do_rd = rdreq && !empty;
    assign drop  = flush_n ? '0 : flush_len;
    assign q     = mem[rptr];

    // NOTE: the storage array is deliberately left out of reset; only the
    // pointers need a known value, and a resettable RAM will not map to memory.
    always_ff @(posedge CLK) begin
        if (do_wr) mem[wptr] <= data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            usedw <= '0;
        end else begin
            wptr  <= wptr + AW'(do_wr) - drop[AW-1:0];
            rptr  <= rptr + AW'(do_rd);
            usedw <= usedw + (AW+1)'(do_wr) - (AW+1)'(do_rd) - drop;
        end
    end

endmodule

// File: rtl/source_msg_packer.sv
// Packs one source's byte stream into 16-bit words and delimits messages by
// inter-byte gap or the 255-word limit. Define SRC_PACKER_DROP_CNT_EN to add DROP_CNT.
module source_msg_packer
    import source_msg_packer_pkg::*;
#(
    parameter int AW         = 9,
    parameter int LQ_AW      = 2,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  DIN,
    input  logic        DIN_VALID,
    input  logic        RD_REQ,
    input  logic        MSG_START,
    output logic [15:0] Q,
    output logic        GOT_FULL_MSG,
    output logic [7:0]  MSG_LEN,
    output logic        PARITY,
    output logic        OVERFLOW
`ifdef SRC_PACKER_DROP_CNT_EN
    ,
    output logic [15:0] DROP_CNT
`endif
);

    localparam int             GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]  GAP_END  = GW'(GAP_CYCLES);
    localparam int             LQ_DEPTH = 1 << LQ_AW;

    state_t        state, state_nxt;
    logic [7:0]    hold, wlen, wlen_inc, rcnt, rcnt_after;
    logic [GW-1:0] gap_cnt;
    logic          gap_hit, close_gap, wr_word, wr_ok, wr_ovf;
    logic          close, push_req, push, lost, overflow, rd_ok, pop;
    logic [15:0]   wr_data, fifo_q;
    logic          fifo_full, fifo_empty;
    logic [AW:0]   unused_usedw;
    len_entry_t    entry, head;

    len_entry_t        lq_mem [LQ_DEPTH];
    logic [LQ_AW-1:0]  lq_wptr, lq_rptr;
    logic [LQ_AW:0]    lq_cnt;
    logic              lq_empty, lq_full;

    word_fifo_sc #(.AW(AW)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .wrreq     (wr_ok),
        .data      (wr_data),
        .rdreq     (rd_ok),
        .flush_n   (!lost),
        .flush_len ((AW+1)'(wlen_inc)),
        .q         (fifo_q),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .usedw     (unused_usedw)
    );

    assign lq_empty = (lq_cnt == '0);
    assign lq_full  = (lq_cnt == (LQ_AW+1)'(LQ_DEPTH));
    assign head     = lq_mem[lq_rptr];

    // NOTE: every always_comb output gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        gap_hit   = !DIN_VALID && (gap_cnt == GAP_END);
        close_gap = (state == S_EVEN || state == S_ODD) && gap_hit;
        wr_word   = (state == S_ODD) && (DIN_VALID || gap_hit);
        wr_data   = DIN_VALID ? {hold, DIN} : {hold, 8'h00};
        wr_ok     = wr_word && !fifo_full;
        wr_ovf    = wr_word && fifo_full;
        wlen_inc  = wlen + 8'(wr_ok);
        close     = close_gap || wr_ovf || (wr_ok && wlen_inc == MSG_LEN_MAX);
        push_req  = close && (wlen_inc != 8'd0);
        push      = push_req && !lq_full;
        lost      = push_req && lq_full;
        overflow  = wr_ovf || lost;
        // The padded half-word only exists when a gap closes an odd message.
        entry     = '{parity: close_gap && wr_ok, len: wlen_inc};

        rd_ok      = RD_REQ && !lq_empty;
        rcnt_after = (MSG_START ? 8'd0 : rcnt) + 8'(rd_ok);
        pop        = rd_ok && (rcnt_after == head.len);

        state_nxt = state;
        unique case (state)
            S_DROP:  if (gap_hit) state_nxt = S_IDLE;
            S_ODD:   if (DIN_VALID) state_nxt = S_EVEN;
            default: if (DIN_VALID) state_nxt = S_ODD;
        endcase
        if (overflow)   state_nxt = S_DROP;
        else if (close) state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold     <= '0;
            wlen     <= '0;
            gap_cnt  <= '0;
            rcnt     <= '0;
            OVERFLOW <= 1'b0;
            lq_wptr  <= '0;
            lq_rptr  <= '0;
            lq_cnt   <= '0;
        end else begin
            if (DIN_VALID && (state == S_IDLE || state == S_EVEN)) hold <= DIN;
            wlen <= close ? 8'd0 : wlen_inc;
            if (DIN_VALID || state == S_IDLE || overflow) gap_cnt <= '0;
            else if (gap_cnt != GAP_END)                   gap_cnt <= gap_cnt + 1'b1;
            rcnt     <= pop ? 8'd0 : rcnt_after;
            OVERFLOW <= overflow;
            lq_wptr  <= lq_wptr + LQ_AW'(push);
            lq_rptr  <= lq_rptr + LQ_AW'(pop);
            lq_cnt   <= lq_cnt + (LQ_AW+1)'(push) - (LQ_AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) lq_mem[lq_wptr] <= entry;
    end

    assign Q            = fifo_empty ? 16'h0000 : fifo_q;
    assign GOT_FULL_MSG = !lq_empty;
    assign MSG_LEN      = lq_empty ? 8'd0 : head.len;
    assign PARITY       = !lq_empty && head.parity;

`ifdef SRC_PACKER_DROP_CNT_EN
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    always_comb begin
        drop_inc = 2'd0;
        if (state == S_DROP && DIN_VALID) drop_inc = 2'd1;
        else if (wr_ovf)                  drop_inc = DIN_VALID ? 2'd2 : 2'd1;
        drop_sum = {1'b0, DROP_CNT} + 17'(drop_inc);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) DROP_CNT <= '0;
        else      DROP_CNT <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule
